// File: rtl/frame_reader_if.sv
// Memory-read and pixel-delivery signal bundle for frame_reader.
// master = the reader; slave = SRAM arbiter plus colour mapper side.
interface frame_reader_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  // Handshake semantics: a memory read is in flight while mem_access is low
  // (two cycles); mem_data must be valid during the second low cycle and
  // mem_addr is meaningful only while mem_access is low. pixel_req is a
  // one-cycle request pulse; one cycle later pixel_valid says whether
  // pixel_out carries a fetched word (1) or black filler (0).
  logic              mem_access;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              pixel_req;
  logic [DATA_W-1:0] pixel_out;
  logic              pixel_valid;

  modport master (
    output mem_access,
    output mem_addr,
    input  mem_data,
    input  pixel_req,
    output pixel_out,
    output pixel_valid
  );

  modport slave (
    input  mem_access,
    input  mem_addr,
    output mem_data,
    output pixel_req,
    input  pixel_out,
    input  pixel_valid
  );
endinterface

// File: rtl/frame_reader.sv
// Frame-buffer sweep reader: prefetches pixel words into a small FIFO and
// hands them to the display path. Optional macro FRAME_READER_UNDERFLOW_STATS_EN.
module frame_reader #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 16,
  parameter int LAST_ADDR  = 307199,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Run,
  input  logic         frame_sync,
  frame_reader_if.master bus,
  output logic         underflow,
  output logic         frame_done,
  output logic [15:0]  underflow_count,
  output logic [2:0]   state_dbg
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(LAST_ADDR);
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH1 = 3'd1;
  localparam logic [2:0] ST_FETCH2 = 3'd2;
  localparam logic [2:0] ST_PUSH   = 3'd3;
  localparam logic [2:0] ST_HOLD   = 3'd4;

  logic [2:0]        state, state_nxt;
  logic [ADDR_W-1:0] addr_cnt;
  logic [DATA_W-1:0] hold_reg;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, count_after;
  logic              fifo_empty, do_push, do_pop, uf_event;

  always_comb begin
    fifo_empty  = (count == '0);
    // frame_sync aborts the push and makes any same-cycle request see an empty FIFO
    do_push     = (state == ST_PUSH) && !frame_sync;
    do_pop      = bus.pixel_req && !fifo_empty && !frame_sync;
    uf_event    = bus.pixel_req && (fifo_empty || frame_sync);
    count_after = count + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_comb begin
    state_nxt = state;
    if (frame_sync) begin
      state_nxt = Run ? ST_FETCH1 : ST_IDLE;
    end else begin
      case (state)
        // a full FIFO left over from a stopped sweep waits in HOLD instead of overrunning
        ST_IDLE:   if (Run) state_nxt = (count < DEPTH_C) ? ST_FETCH1 : ST_HOLD;
        ST_FETCH1: state_nxt = ST_FETCH2;
        ST_FETCH2: state_nxt = ST_PUSH;
        ST_PUSH: begin
          if (!Run)                        state_nxt = ST_IDLE;
          else if (count_after == DEPTH_C) state_nxt = ST_HOLD;
          else                             state_nxt = ST_FETCH1;
        end
        ST_HOLD: begin
          if (!Run)                  state_nxt = ST_IDLE;
          else if (count < DEPTH_C)  state_nxt = ST_FETCH1;
        end
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state           <= ST_IDLE;
      addr_cnt        <= '0;
      hold_reg        <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      bus.pixel_out   <= '0;
      bus.pixel_valid <= 1'b0;
      underflow       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_FETCH2) hold_reg <= bus.mem_data;

      if (frame_sync) begin
        addr_cnt <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
      end else begin
        if (do_push) begin
          wr_ptr   <= wr_ptr + 1'b1;
          addr_cnt <= (addr_cnt == LAST) ? '0 : addr_cnt + 1'b1;
        end
        if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count_after;
      end

      if (uf_event) begin
        bus.pixel_out   <= '0;
        bus.pixel_valid <= 1'b0;
        underflow       <= 1'b1;
      end else if (do_pop) begin
        bus.pixel_out   <= fifo_mem[rd_ptr];
        bus.pixel_valid <= 1'b1;
        underflow       <= 1'b0;
      end else begin
        bus.pixel_valid <= 1'b0;
        underflow       <= 1'b0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (do_push) fifo_mem[wr_ptr] <= hold_reg;
  end

  assign bus.mem_access = !((state == ST_FETCH1) || (state == ST_FETCH2));
  assign bus.mem_addr   = addr_cnt;
  assign frame_done     = do_push && (addr_cnt == LAST) && !Reset;
  assign state_dbg      = state;

`ifdef FRAME_READER_UNDERFLOW_STATS_EN
  logic [15:0] uf_cnt;

  always_ff @(posedge Clk) begin
    if (Reset)                                uf_cnt <= '0;
    else if (uf_event && (uf_cnt != 16'hFFFF)) uf_cnt <= uf_cnt + 16'd1;
  end

  assign underflow_count = uf_cnt;
`else
  assign underflow_count = '0;
`endif

endmodule

// File: doc/frame_reader.md
Name: frame_reader

Overview:
- Read-side counterpart of the screen-sweep writer.
- Walks the frame buffer from address 0 to LAST_ADDR using the same two-cycle, active-low memory-access read handshake.
- Prefetches pixel words into a small FIFO and hands one pixel to the VGA output path per pixel request.
- Sits between the SRAM arbiter and the colour mapper, so display timing is decoupled from memory latency.

Parameters:
ADDR_W, 20, address/counter width
DATA_W, 16, pixel word width
LAST_ADDR, 307199, final pixel address (640*480-1)
FIFO_DEPTH, 4, prefetch depth; must be a power of two, minimum 2

Ports:
Clk  in  1  system clock, all logic on posedge
Reset  in  1  synchronous, active-high
Run  in  1  level; enables fetching
frame_sync  in  1  one-cycle pulse; restart at address 0 (vsync-aligned)
pixel_req  in  1  one-cycle pulse; consumer wants the next pixel
mem_data  in  DATA_W  SRAM read data, valid during FETCH2
mem_access  out  1  active-low memory read strobe
mem_addr  out  ADDR_W  current fetch address
pixel_out  out  DATA_W  pixel handed to consumer
pixel_valid  out  1  pixel_out holds a real fetched word this cycle
underflow  out  1  one-cycle pulse: request arrived with FIFO empty
frame_done  out  1  one-cycle pulse when the word at LAST_ADDR is pushed
underflow_count  out  16  see Optional Feature

Behaviour:
- Reset values:
  - State IDLE, address counter 0, FIFO empty (count 0).
  - mem_access=1, mem_addr=0, pixel_out=0.
  - pixel_valid=0, underflow=0, frame_done=0, underflow_count=0.
- Priority order: Reset > frame_sync > all other events.
- States:
  - IDLE: mem_access=1. Run=1 -> FETCH1.
  - FETCH1: mem_access=0, mem_addr=counter. Always -> FETCH2.
  - FETCH2: mem_access=0. mem_data captured into the holding register at the clock edge ending this cycle. Always -> PUSH.
  - PUSH: mem_access=1. Holding register written to the FIFO tail.
    - Counter +1; at LAST_ADDR it wraps to 0 and frame_done pulses in this cycle.
    - Run=0 -> IDLE. Otherwise FIFO full after the push -> HOLD, else FETCH1.
  - HOLD: mem_access=1. Run=0 -> IDLE. FIFO count < FIFO_DEPTH -> FETCH1.
- Fetch rate: with no back-pressure, one word per 3 cycles.
- mem_addr holds the counter value in every state; it is only meaningful while mem_access=0.
- Run deasserted mid-fetch (FETCH1/FETCH2): the fetch completes through PUSH, then IDLE. No word is ever dropped.
- Consumer side:
  - pixel_req with FIFO non-empty: the head word is popped. Next cycle pixel_out=word and pixel_valid=1 (latency 1).
  - pixel_req with FIFO empty: next cycle pixel_out=0 (black), pixel_valid=0, underflow=1. No bypass from the holding register.
  - No request: pixel_valid=0 next cycle; pixel_out holds its last value.
- Push and pop in the same cycle: both occur, count unchanged. FIFO pointers wrap modulo FIFO_DEPTH.
- frame_sync:
  - Flushes the FIFO, zeroes the counter, and aborts any in-progress fetch (its data is discarded, no push).
  - Next state is FETCH1 if Run=1, else IDLE.
  - A pixel_req in the same cycle is treated as against an empty FIFO: underflow pulses.
  - Does not clear underflow_count.
- Counter arithmetic: ADDR_W unsigned. Never exceeds LAST_ADDR; wraps to 0 only via PUSH at LAST_ADDR or via frame_sync.

Optional Feature:
- Macro FRAME_READER_UNDERFLOW_STATS_EN.
- Defined: underflow_count is a 16-bit counter.
  - Increments by 1 on every underflow pulse and saturates at 0xFFFF.
  - Cleared only by Reset.
- Undefined: underflow_count is tied to 0 and no counter logic is built. All other behaviour is identical.

Test Plan:
- Reset, then Run=1 with mem_data=addr[15:0] and no pixel_req -> mem_access low in cycles 2-3, 5-6, 8-9, 11-12; FIFO fills with 0,1,2,3; HOLD entered with counter=4, mem_access stays 1.
- Full FIFO, single pixel_req -> next cycle pixel_out=0x0000, pixel_valid=1; the block leaves HOLD and fetches address 4.
- Steady sweep with counter preset to LAST_ADDR-1 and consumer popping every 3 cycles -> frame_done pulses exactly once, on the PUSH of address 307199; the next mem_addr during mem_access=0 is 0.
- pixel_req every cycle from the start of fetching -> underflow pulses with pixel_out=0 and pixel_valid=0 whenever the FIFO is empty; with the macro defined, underflow_count equals the number of underflow pulses.
- frame_sync asserted during FETCH2 at counter=100 with FIFO holding 2 words -> that word is not pushed; FIFO count becomes 0; FETCH1 issues mem_addr=0 in the following cycle.
- Run dropped during FETCH1 at address 7 -> FETCH2 and PUSH still occur (word 7 enters the FIFO), then IDLE with mem_access=1 and counter=8.
